// File: rtl/exec_commit_stage_pkg.sv
// exec_pkg: condition codes, flag indices and pipeline control type for the execute/commit stage
package exec_pkg;
  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_write;
    logic pc_src;
  } mctl_t;
endpackage

// File: rtl/exec_commit_stage_if.sv
// exec_commit_stage_if: execute-stage inputs and memory-stage outputs of the commit stage
interface exec_commit_stage_if #(
  parameter int N = 32,
  parameter int RA_W = 4,
  parameter int CNT_W = 16
);
  logic in_valid;
  logic [3:0] Cond;
  logic [1:0] FlagW;
  logic RegW;
  logic MemW;
  logic PCS;
  logic [RA_W-1:0] Rd;
  logic [N-1:0] ALUResult;
  logic [3:0] ALUFlags;
  logic [N-1:0] WriteData;
  logic CondEx;
  logic [3:0] Flags;
  logic m_valid;
  logic m_RegWrite;
  logic m_MemWrite;
  logic m_PCSrc;
  logic [RA_W-1:0] m_Rd;
  logic [N-1:0] m_ALUResult;
  logic [N-1:0] m_WriteData;
  logic [CNT_W-1:0] cnt_exec;
  logic [CNT_W-1:0] cnt_squash;
  modport master (
    output in_valid, Cond, FlagW, RegW, MemW, PCS, Rd, ALUResult, ALUFlags, WriteData,
    input CondEx, Flags, m_valid, m_RegWrite, m_MemWrite, m_PCSrc, m_Rd, m_ALUResult,
    m_WriteData, cnt_exec, cnt_squash
  );
  modport slave (
    input in_valid, Cond, FlagW, RegW, MemW, PCS, Rd, ALUResult, ALUFlags, WriteData,
    output CondEx, Flags, m_valid, m_RegWrite, m_MemWrite, m_PCSrc, m_Rd, m_ALUResult,
    m_WriteData, cnt_exec, cnt_squash
  );
endinterface

// File: rtl/exec_commit_stage_cond_eval.sv
// cond_eval: ARM condition-field decode against the NZCV flags
module cond_eval
  import exec_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic pass
);
  logic n, z, c, v;
  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];
  // map each condition code to its flag predicate
  always_comb begin
    pass = 1'b0;
    case (cond_e'(Cond))
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = n == v;
      LT: pass = n != v;
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/exec_commit_stage.sv
// exec_commit_stage: condition check, NZCV ownership, gated EX/MEM pipeline register and counters
module exec_commit_stage
  import exec_pkg::*;
#(
  parameter int N = 32,
  parameter int RA_W = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  input logic stall,
  input logic flush,
  exec_commit_stage_if.slave ex
);
  logic pass, cond_ex, adv, fire, squash;
  logic [3:0] flags_q, flags_d;
  mctl_t mctl_q, mctl_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [N-1:0] res_q, res_d, wd_q, wd_d;
  logic [CNT_W-1:0] cnt_exec_q, cnt_exec_d, cnt_squash_q, cnt_squash_d;
  cond_eval u_cond_eval (
    .Cond(ex.Cond),
    .Flags(flags_q),
    .pass(pass)
  );
  assign cond_ex = pass & ex.in_valid;
  assign adv = ~stall & ~flush;
  assign fire = cond_ex & adv;
  assign squash = ex.in_valid & ~pass & adv;
  // next state: flags on fire, pipeline load on advance, bubble on flush, saturating counters
  always_comb begin
    flags_d[FLAG_N:FLAG_Z] = (fire & ex.FlagW[FLAGW_NZ]) ? ex.ALUFlags[FLAG_N:FLAG_Z] : flags_q[FLAG_N:FLAG_Z];
    flags_d[FLAG_C:FLAG_V] = (fire & ex.FlagW[FLAGW_CV]) ? ex.ALUFlags[FLAG_C:FLAG_V] : flags_q[FLAG_C:FLAG_V];
    mctl_d = flush ? '0 : stall ? mctl_q :
             '{valid: ex.in_valid, reg_write: ex.RegW & cond_ex,
               mem_write: ex.MemW & cond_ex, pc_src: ex.PCS & cond_ex};
    rd_d = adv ? ex.Rd : rd_q;
    res_d = adv ? ex.ALUResult : res_q;
    wd_d = adv ? ex.WriteData : wd_q;
    cnt_exec_d = (fire & ~&cnt_exec_q) ? cnt_exec_q + CNT_W'(1) : cnt_exec_q;
    cnt_squash_d = (squash & ~&cnt_squash_q) ? cnt_squash_q + CNT_W'(1) : cnt_squash_q;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      mctl_q <= '0;
      rd_q <= '0;
      res_q <= '0;
      wd_q <= '0;
      cnt_exec_q <= '0;
      cnt_squash_q <= '0;
    end else begin
      flags_q <= flags_d;
      mctl_q <= mctl_d;
      rd_q <= rd_d;
      res_q <= res_d;
      wd_q <= wd_d;
      cnt_exec_q <= cnt_exec_d;
      cnt_squash_q <= cnt_squash_d;
    end
  end
  assign ex.CondEx = cond_ex;
  assign ex.Flags = flags_q;
  assign ex.m_valid = mctl_q.valid;
  assign ex.m_RegWrite = mctl_q.reg_write;
  assign ex.m_MemWrite = mctl_q.mem_write;
  assign ex.m_PCSrc = mctl_q.pc_src;
  assign ex.m_Rd = rd_q;
  assign ex.m_ALUResult = res_q;
  assign ex.m_WriteData = wd_q;
  assign ex.cnt_exec = cnt_exec_q;
  assign ex.cnt_squash = cnt_squash_q;
endmodule

// File: tb/tb_exec_commit_stage.sv
// tb_exec_commit_stage: directed plan plus random stimulus checked against a behavioural model
module tb_exec_commit_stage;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset, stall, flush;
  int checks = 0;
  int failures = 0;
  logic last_ce;
  logic [3:0] mf;
  logic mv, mrw, mmw, mpc;
  logic [3:0] mrd;
  logic [31:0] mres, mwd;
  int ce, cs;
  exec_commit_stage_if #(.N(32), .RA_W(4), .CNT_W(CW)) bus ();
  exec_commit_stage #(.N(32), .RA_W(4), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .ex(bus)
  );
  always #5 clk = ~clk;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return cy;
      4'd3: return !cy;
      4'd4: return n;
      4'd5: return !n;
      4'd6: return v;
      4'd7: return !v;
      4'd8: return cy && !z;
      4'd9: return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic fl, input logic iv,
                      input logic [3:0] c, input logic [1:0] fw, input logic rw,
                      input logic mw, input logic ps, input logic [3:0] af);
    logic ok;
    logic [3:0] rd;
    logic [31:0] res, wd;
    rd = 4'($urandom);
    res = $urandom;
    wd = $urandom;
    reset = r; stall = s; flush = fl;
    bus.in_valid = iv; bus.Cond = c; bus.FlagW = fw; bus.RegW = rw; bus.MemW = mw;
    bus.PCS = ps; bus.Rd = rd; bus.ALUResult = res; bus.ALUFlags = af; bus.WriteData = wd;
    #1;
    ok = cond_ok(c, mf) && iv;
    last_ce = bus.CondEx;
    check("CondEx", 64'(bus.CondEx), 64'(ok));
    @(posedge clk);
    if (r) begin
      mf = 0; mv = 0; mrw = 0; mmw = 0; mpc = 0; mrd = 0; mres = 0; mwd = 0; ce = 0; cs = 0;
    end else if (fl) begin
      mv = 0; mrw = 0; mmw = 0; mpc = 0;
    end else if (!s) begin
      if (ok && fw[1]) mf[3:2] = af[3:2];
      if (ok && fw[0]) mf[1:0] = af[1:0];
      mv = iv; mrw = rw && ok; mmw = mw && ok; mpc = ps && ok;
      mrd = rd; mres = res; mwd = wd;
      if (ok) ce = (ce == CMAX) ? CMAX : ce + 1;
      else if (iv) cs = (cs == CMAX) ? CMAX : cs + 1;
    end
    #1;
    check("Flags", 64'(bus.Flags), 64'(mf));
    check("m_valid", 64'(bus.m_valid), 64'(mv));
    check("m_RegWrite", 64'(bus.m_RegWrite), 64'(mrw));
    check("m_MemWrite", 64'(bus.m_MemWrite), 64'(mmw));
    check("m_PCSrc", 64'(bus.m_PCSrc), 64'(mpc));
    check("m_Rd", 64'(bus.m_Rd), 64'(mrd));
    check("m_ALUResult", 64'(bus.m_ALUResult), 64'(mres));
    check("m_WriteData", 64'(bus.m_WriteData), 64'(mwd));
    check("cnt_exec", 64'(bus.cnt_exec), 64'(ce));
    check("cnt_squash", 64'(bus.cnt_squash), 64'(cs));
  endtask

  initial begin
    mf = 0; mv = 0; mrw = 0; mmw = 0; mpc = 0; mrd = 0; mres = 0; mwd = 0; ce = 0; cs = 0;
    @(posedge clk);
    #1;
    step(1, 1, 1, 1, 4'hE, 2'b11, 1, 1, 1, 4'hF);
    step(1, 0, 0, 1, 4'hE, 2'b11, 1, 1, 1, 4'hF);
    check("reset_flags", 64'(bus.Flags), 64'h0);
    check("reset_cnt_exec", 64'(bus.cnt_exec), 64'h0);
    check("reset_m_valid", 64'(bus.m_valid), 64'h0);
    step(0, 0, 0, 1, 4'h1, 2'b00, 0, 0, 0, 4'h0);
    check("first_NE_pass", 64'(last_ce), 64'h1);
    step(0, 0, 0, 1, 4'hE, 2'b11, 0, 0, 0, 4'b0110);
    check("cmp_flags", 64'(bus.Flags), 64'h6);
    step(0, 0, 0, 1, 4'h0, 2'b00, 1, 0, 0, 4'h0);
    check("eq_regwrite", 64'(bus.m_RegWrite), 64'h1);
    step(0, 0, 0, 1, 4'h1, 2'b00, 1, 0, 0, 4'h0);
    check("ne_regwrite", 64'(bus.m_RegWrite), 64'h0);
    check("ne_squash", 64'(bus.cnt_squash), 64'h1);
    step(0, 0, 0, 1, 4'hE, 2'b11, 0, 0, 0, 4'hF);
    step(0, 0, 0, 1, 4'hE, 2'b10, 0, 0, 0, 4'h0);
    check("partial_flags", 64'(bus.Flags), 64'h3);
    step(0, 0, 0, 1, 4'hE, 2'b11, 0, 0, 0, 4'b1000);
    step(0, 0, 0, 1, 4'hB, 2'b00, 0, 0, 0, 4'h0);
    check("LT_pass", 64'(last_ce), 64'h1);
    step(0, 0, 0, 1, 4'hA, 2'b00, 0, 0, 0, 4'h0);
    check("GE_fail", 64'(last_ce), 64'h0);
    step(0, 0, 0, 1, 4'hC, 2'b00, 0, 0, 0, 4'h0);
    check("GT_fail", 64'(last_ce), 64'h0);
    step(0, 0, 0, 1, 4'hD, 2'b00, 0, 0, 0, 4'h0);
    check("LE_pass", 64'(last_ce), 64'h1);
    step(0, 0, 0, 1, 4'hF, 2'b00, 0, 0, 0, 4'h0);
    check("NV_fail", 64'(last_ce), 64'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 2'b11, 1'b1, 1'b1, 1'b1, 4'($urandom));
    check("stall_flags", 64'(bus.Flags), 64'h8);
    step(0, 1, 1, 1, 4'hE, 2'b11, 1, 0, 0, 4'h5);
    check("flush_valid", 64'(bus.m_valid), 64'h0);
    check("flush_regwrite", 64'(bus.m_RegWrite), 64'h0);
    check("flush_flags", 64'(bus.Flags), 64'h8);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 2'b00, 1'b1, 1'b0, 1'b0, 4'h0);
    check("cnt_exec_sat", 64'(bus.cnt_exec), 64'(CMAX));
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           1'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 4'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
